// File: rtl/snn_feat_pkg.sv
// Shared widths, feature-record layout and sentinels for the spike feature
// extraction stages downstream of the AdEx neuron.
package snn_feat_pkg;

   localparam int WIN_LEN = 1000;
   localparam int WIN_W   = 10;
   localparam int CNT_W   = 8;
   localparam int ISI_W   = 12;

   typedef struct packed {
      logic [CNT_W-1:0] cnt;
      logic [ISI_W-1:0] min_isi;
      logic [WIN_W-1:0] first_lat;
   } feat_rec_t;

   // "No measurement" markers for min_isi and first_lat at default widths.
   localparam logic [ISI_W-1:0] ISI_NONE = '1;
   localparam logic [WIN_W-1:0] LAT_NONE = '1;

endpackage

// File: rtl/isi_tracker.sv
// Counts enabled cycles since the last spike and strobes a measurement when a
// spike arrives with a previous spike on record (including earlier windows).
module isi_tracker #(
   parameter int ISI_W = snn_feat_pkg::ISI_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             spike,
   output logic [ISI_W-1:0] isi,
   output logic             isi_valid
);

   localparam logic [ISI_W-1:0] ISI_MAX = '1;

   logic [ISI_W-1:0] isi_cnt_reg;
   logic             isi_armed_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         isi_cnt_reg   <= '0;
         isi_armed_reg <= 1'b0;
      end else if (en) begin
         if (spike) begin
            isi_cnt_reg   <= ISI_W'(1);
            isi_armed_reg <= 1'b1;
         end else if (isi_armed_reg && isi_cnt_reg != ISI_MAX) begin
            isi_cnt_reg <= isi_cnt_reg + ISI_W'(1);
         end
      end
   end

   assign isi       = isi_cnt_reg;
   assign isi_valid = en && spike && isi_armed_reg;

endmodule

// File: rtl/spike_window_encoder.sv
// Builds a {count, min ISI, first-spike latency} record per window of enabled
// cycles and offers it on a single-register valid/ready port; late records drop.
module spike_window_encoder #(
   parameter int WIN_LEN = snn_feat_pkg::WIN_LEN,
   parameter int WIN_W   = snn_feat_pkg::WIN_W,
   parameter int CNT_W   = snn_feat_pkg::CNT_W,
   parameter int ISI_W   = snn_feat_pkg::ISI_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             spike_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] spike_cnt,
   output logic [ISI_W-1:0] min_isi,
   output logic [WIN_W-1:0] first_lat,
   output logic             drop
);

   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [ISI_W-1:0] ISI_NONE = '1;
   localparam logic [WIN_W-1:0] LAT_NONE = '1;
   localparam logic [WIN_W-1:0] LAST_IDX = WIN_W'(WIN_LEN - 1);

   logic [WIN_W-1:0] win_idx_reg;
   logic [CNT_W-1:0] acc_cnt_reg, acc_cnt_next;
   logic [ISI_W-1:0] acc_min_reg, acc_min_next;
   logic [WIN_W-1:0] acc_lat_reg, acc_lat_next;

   logic             out_valid_reg;
   logic [CNT_W-1:0] out_cnt_reg;
   logic [ISI_W-1:0] out_min_reg;
   logic [WIN_W-1:0] out_lat_reg;
   logic             drop_reg;

   logic [ISI_W-1:0] isi;
   logic             isi_valid;
   logic             close;
   logic             out_free;

   isi_tracker #(.ISI_W(ISI_W)) u_isi (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .spike     (spike_in),
      .isi       (isi),
      .isi_valid (isi_valid)
   );

   // Window values including the current cycle, so the closing spike counts.
   always_comb begin
      acc_cnt_next = acc_cnt_reg;
      acc_lat_next = acc_lat_reg;
      acc_min_next = acc_min_reg;
      if (en && spike_in) begin
         if (acc_cnt_reg != CNT_MAX)
            acc_cnt_next = acc_cnt_reg + CNT_W'(1);
         if (acc_cnt_reg == '0)
            acc_lat_next = win_idx_reg;
      end
      if (isi_valid && isi < acc_min_reg)
         acc_min_next = isi;
   end

   assign close    = en && (win_idx_reg == LAST_IDX);
   assign out_free = !out_valid_reg || out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         win_idx_reg <= '0;
         acc_cnt_reg <= '0;
         acc_min_reg <= ISI_NONE;
         acc_lat_reg <= LAT_NONE;
      end else if (en) begin
         if (close) begin
            win_idx_reg <= '0;
            acc_cnt_reg <= '0;
            acc_min_reg <= ISI_NONE;
            acc_lat_reg <= LAT_NONE;
         end else begin
            win_idx_reg <= win_idx_reg + WIN_W'(1);
            acc_cnt_reg <= acc_cnt_next;
            acc_min_reg <= acc_min_next;
            acc_lat_reg <= acc_lat_next;
         end
      end
   end

   // A close may load in the same cycle the held record is accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_reg <= 1'b0;
         out_cnt_reg   <= '0;
         out_min_reg   <= '0;
         out_lat_reg   <= '0;
         drop_reg      <= 1'b0;
      end else if (close) begin
         if (out_free) begin
            out_valid_reg <= 1'b1;
            out_cnt_reg   <= acc_cnt_next;
            out_min_reg   <= acc_min_next;
            out_lat_reg   <= acc_lat_next;
         end else begin
            drop_reg <= 1'b1;
         end
      end else if (out_valid_reg && out_ready) begin
         out_valid_reg <= 1'b0;
      end
   end

   assign out_valid = out_valid_reg;
   assign spike_cnt = out_cnt_reg;
   assign min_isi   = out_min_reg;
   assign first_lat = out_lat_reg;
   assign drop      = drop_reg;

endmodule

// File: doc/spike_window_encoder.md
# spike_window_encoder

Downstream stage of the AdEx neuron: consumes its one-cycle `spikes` pulse train and, over fixed-length windows of enabled cycles, builds a feature record (spike count, minimum inter-spike interval, first-spike latency) for the ECG classifier. Each record is presented on a valid/ready output port. Back-pressure never stalls spike capture; a window that cannot be delivered is dropped and flagged.

## Interface
- `WIN_LEN`, 1000: window length in enabled cycles, 2 to 2^WIN_W−1.
- `WIN_W`, 10: width of window index and `first_lat`.
- `CNT_W`, 8: width of `spike_cnt`, saturating.
- `ISI_W`, 12: width of ISI tracking and `min_isi`, saturating.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  window advance and spike capture enable.
- `spike_in`  in  1  neuron spike pulse; each high cycle is one spike.
- `out_valid`  out  1  a feature record is held.
- `out_ready`  in  1  consumer accepts the record.
- `spike_cnt`  out  CNT_W  spikes in the window.
- `min_isi`  out  ISI_W  smallest ISI in the window; all-ones if fewer than 2 spikes contributed.
- `first_lat`  out  WIN_W  window index of the first spike; all-ones if none.
- `drop`  out  1  sticky; a completed window was discarded.

## Operation
- **Reset** (`rst`=1 at an edge) clears the following:
  - `win_idx`=0, accumulators cleared, `isi_cnt`=0, `isi_armed`=0.
  - `out_valid`=0, `drop`=0; all data outputs 0.
  - Reset overrides everything else, including mid-window operation and a pending record.
- **Enable gating.** `en`=0 freezes all state: `win_idx`, accumulators and `isi_cnt`; `spike_in` is ignored. The output handshake still operates while `en`=0.
- **Enabled cycle**, with `idx`=`win_idx`:
  - **Count:** if `spike_in`, `acc_cnt` increments, saturating at 2^CNT_W−1.
  - **First spike:** if `spike_in` and this is the window's first spike, `acc_lat`←`idx`.
  - **ISI counter:** `isi_cnt` is the number of enabled cycles since the last spike, saturating at 2^ISI_W−1. On a spike `isi_cnt`←1; otherwise it increments if `isi_armed`. Spikes on enabled cycles t1 and t2 give ISI = t2−t1.
  - **Minimum ISI:** if `spike_in` and `isi_armed`, `acc_min`←min(`acc_min`, `isi_cnt`). Then `isi_armed`←1.
  - **ISI carry-over:** `isi_cnt` and `isi_armed` carry across window boundaries. The first spike of a window can therefore register an ISI measured from the previous window's last spike.
  - **Window index:** `win_idx` wraps from WIN_LEN−1 to 0.
- **Window close** happens on the enabled cycle with `idx`=WIN_LEN−1:
  - The final record includes that cycle's spike.
  - Accumulators reset to `acc_cnt`=0, `acc_min`=all-ones, `acc_lat`=all-ones for the next window.
- **Output register update on close:**
  - **Load:** if the register is free (`out_valid`=0, or `out_valid`&`out_ready` this cycle), it loads the record and `out_valid`←1.
  - **Drop:** otherwise the record is discarded, `drop`←1, and the held record is unchanged.
- **Handshake:**
  - A transfer occurs on a cycle with `out_valid`&`out_ready`.
  - With no close pending, a transfer sets `out_valid`←0.
  - Data must not change while `out_valid`=1 and the record has not been accepted.
  - `out_ready` may be high while `out_valid`=0; it has no effect.

## Timing
- Record latency: visible on `out_valid` one cycle after the closing enabled edge.
- Maximum throughput is one record per WIN_LEN enabled cycles. There is no internal queue beyond the single output register.
- **Simultaneous close and accept** on the same cycle: the old record transfers and the new record loads, so `out_valid` stays 1. No drop.
- `drop` clears only on `rst`.
- Comparisons are unsigned. Saturation applies before the `acc_min` compare.

## Structure
- Shared package `snn_feat_pkg` holds:
  - width constants `WIN_W`, `CNT_W`, `ISI_W`;
  - a packed feature-record typedef {cnt, min_isi, first_lat};
  - the all-ones sentinel constants.
- One sub-module: `isi_tracker`. It contains `isi_cnt`, `isi_armed` and the saturating counter, and outputs the current ISI plus a measurement-valid strobe.
- The top level holds the window counter, accumulators and output register with handshake.

## Test plan
- **Periodic spikes:** WIN_LEN=20, `en`=1, `out_ready`=1, spikes at cycles 3, 8, 13, 18 → record cnt=4, min_isi=5, first_lat=3, valid asserted after cycle 19.
- **Silent window:** no spikes for a full window → cnt=0, min_isi=all-ones, first_lat=all-ones. A single-spike window gives min_isi=all-ones, except for carry-over from a previous window.
- **Back-pressure:** hold `out_ready`=0 across two closes → first record held stable, second discarded, `drop`=1. Raise `out_ready` exactly at the third close → transfer plus load, `out_valid` stays 1.
- **Enable gating:** `en`=0 for 7 cycles mid-window with `spike_in` toggling → no count change, and the close is delayed by exactly 7 cycles.
- **Saturation:** CNT_W=3 with a continuous `spike_in` over a 20-cycle window → cnt=7 and min_isi=1. ISI_W=4 with spikes 30 cycles apart → min_isi=15.
- **Mid-window reset:** `rst` at `idx`=10 with `out_valid`=1 and `drop`=1 → all outputs 0. The next window starts at idx 0 and the first spike yields no ISI.
